// File: rtl/fir_pkg.sv
// Shared definitions for the adaptive FIR coefficient-update path.
//   DATA_W      : sample / coefficient word width (Q16.16 by default)
//   lms_state_t : sequencing states of the LMS update engine
//   sat32       : clamp a wide signed value into the 32-bit signed range
//   clampTaps   : map a requested tap count onto the legal range 1..maxTaps
package fir_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ERR    = 2'd1,
    UPDATE = 2'd2,
    STREAM = 2'd3
  } lms_state_t;

  localparam logic signed [63:0] SAT_MAX = 64'sd2147483647;
  localparam logic signed [63:0] SAT_MIN = -64'sd2147483648;

  // Any 33-bit error or 64-bit accumulator result is sign-extended into v.
  function automatic logic signed [DATA_W-1:0] sat32(input logic signed [63:0] v);
    if (v > SAT_MAX) begin
      return 32'h7FFF_FFFF;
    end else if (v < SAT_MIN) begin
      return 32'h8000_0000;
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

  // A request of zero still runs one tap; anything above the bank depth uses the whole bank.
  function automatic int unsigned clampTaps(input logic [31:0] tc, input int unsigned maxTaps);
    if (tc == 32'd0) begin
      return 1;
    end else if (tc > maxTaps) begin
      return maxTaps;
    end else begin
      return tc;
    end
  endfunction

endpackage

// File: rtl/fir_lms_update_if.sv
// Bundle of the stream, control and status signals of the LMS update stage.
//   master : the side that produces samples / filter outputs (datapath or bench)
//   slave  : the LMS update stage itself
// Inputs to the stage: tap_count, enable, x_valid/x_data/d_data, y_valid/y_data, clear_status.
// Outputs: err_valid/err_data, coeff_restart/coeff_valid/coeff_data, busy and sticky flags.
interface fir_lms_update_if;
  import fir_pkg::*;

  logic [DATA_W-1:0]        tap_count;
  logic                     enable;
  logic                     x_valid;
  logic signed [DATA_W-1:0] x_data;
  logic signed [DATA_W-1:0] d_data;
  logic                     y_valid;
  logic signed [DATA_W-1:0] y_data;
  logic                     clear_status;

  logic                     err_valid;
  logic signed [DATA_W-1:0] err_data;
  logic                     coeff_restart;
  logic                     coeff_valid;
  logic signed [DATA_W-1:0] coeff_data;
  logic                     busy;
  logic                     overrun;
  logic                     underrun;
  logic                     y_dropped;

  modport master (
    output tap_count, enable, x_valid, x_data, d_data, y_valid, y_data, clear_status,
    input  err_valid, err_data, coeff_restart, coeff_valid, coeff_data,
    input  busy, overrun, underrun, y_dropped
  );

  modport slave (
    input  tap_count, enable, x_valid, x_data, d_data, y_valid, y_data, clear_status,
    output err_valid, err_data, coeff_restart, coeff_valid, coeff_data,
    output busy, overrun, underrun, y_dropped
  );

endinterface

// File: rtl/fir_desired_fifo.sv
// Small synchronous FIFO holding desired samples d[n] until the matching y[n] arrives.
//   clk, rstn : clock, asynchronous active-low reset (FIFO empties)
//   i_push    : write i_data; ignored when full
//   i_pop     : drop the head entry; ignored when empty
//   o_head    : current head entry (valid while !o_empty)
//   o_full    : DEPTH entries stored
//   o_empty   : no entries stored
// DEPTH must be a power of two of at least 2 so the pointers wrap naturally.
module fir_desired_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;
  logic             w_doPush;
  logic             w_doPop;

  // Full/empty are judged on the pre-edge occupancy, so a push into a full FIFO
  // is dropped even when a pop happens in the same cycle.
  assign o_full   = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_head   = r_mem[r_rdPtr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fir_lms_update.sv
// LMS coefficient-update stage closing the adaptive FIR loop.
//   clk, rstn : clock, asynchronous active-low reset (aborts any update or stream)
//   bus       : slave side of fir_lms_update_if
//     - x_valid/x_data/d_data feed the sample history and the desired-sample FIFO
//     - y_valid/y_data is paired with the oldest desired sample; e = sat32(d - y)
//     - every w[k], k < N, gets w[k] = sat32(w[k] + ((e * x[n-k]) >>> (FRAC_W+MU_SHIFT)))
//     - the whole bank w[0..N-1] is then streamed after a coeff_restart pulse
module fir_lms_update
  import fir_pkg::*;
#(
  parameter int MAX_TAPS     = 16,
  parameter int FRAC_W       = 16,
  parameter int MU_SHIFT     = 8,
  parameter int D_FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  fir_lms_update_if.slave  bus
);

  localparam int IDX_W = $clog2(MAX_TAPS);
  localparam int CNT_W = $clog2(MAX_TAPS + 2);
  localparam int SHIFT = FRAC_W + MU_SHIFT;

  lms_state_t               r_state;
  lms_state_t               w_nextState;
  logic signed [DATA_W-1:0] r_xHist [MAX_TAPS];
  logic signed [DATA_W-1:0] r_snap  [MAX_TAPS];
  logic signed [DATA_W-1:0] r_w     [MAX_TAPS];
  logic [CNT_W-1:0]         r_n;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [DATA_W-1:0] r_d;
  logic signed [DATA_W-1:0] r_y;
  logic signed [DATA_W-1:0] r_err;
  logic                     r_errValid;
  logic                     r_restart;
  logic                     r_coeffValid;
  logic signed [DATA_W-1:0] r_coeffData;
  logic                     r_overrun;
  logic                     r_underrun;
  logic                     r_yDropped;

  logic                     w_accept;
  logic                     w_fifoFull;
  logic                     w_fifoEmpty;
  logic [DATA_W-1:0]        w_fifoHead;
  logic                     w_lastTap;
  logic                     w_streamDone;
  logic [IDX_W-1:0]         w_idx;
  logic signed [63:0]       w_diff;
  logic signed [63:0]       w_product;
  logic signed [63:0]       w_delta;
  logic signed [63:0]       w_sum;

  fir_desired_fifo #(
    .DEPTH (D_FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_dFifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (bus.x_valid),
    .i_data  (bus.d_data),
    .i_pop   (w_accept),
    .o_head  (w_fifoHead),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty)
  );

  assign w_accept = (r_state == IDLE) && bus.enable && bus.y_valid && !w_fifoEmpty;

  // r_cnt walks taps 0..N-1 in UPDATE; in STREAM count 0 is the restart pulse,
  // counts 1..N carry words w[0..N-1] and count N+1 is the return to IDLE.
  assign w_lastTap    = (r_cnt == r_n - 1'b1);
  assign w_streamDone = (r_cnt == r_n + 1'b1);
  assign w_idx        = IDX_W'((r_state == STREAM) ? r_cnt - 1'b1 : r_cnt);

  assign w_diff    = 64'(r_d) - 64'(r_y);
  assign w_product = 64'(r_err) * 64'(r_snap[w_idx]);
  assign w_delta   = w_product >>> SHIFT;
  assign w_sum     = 64'(r_w[w_idx]) + w_delta;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state selection.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = ERR;
      ERR:     w_nextState = UPDATE;
      UPDATE:  if (w_lastTap) w_nextState = STREAM;
      STREAM:  if (w_streamDone) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Sample history, snapshot on accept, error, coefficient update and streaming.
  // The snapshot copies the history as it was before any same-cycle shift.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < MAX_TAPS; k++) begin
        r_xHist[k] <= '0;
        r_snap[k]  <= '0;
        r_w[k]     <= '0;
      end
      r_n          <= '0;
      r_cnt        <= '0;
      r_d          <= '0;
      r_y          <= '0;
      r_err        <= '0;
      r_errValid   <= 1'b0;
      r_restart    <= 1'b0;
      r_coeffValid <= 1'b0;
      r_coeffData  <= '0;
    end else begin
      r_errValid   <= 1'b0;
      r_restart    <= 1'b0;
      r_coeffValid <= 1'b0;

      if (bus.x_valid) begin
        r_xHist[0] <= bus.x_data;
        for (int k = 1; k < MAX_TAPS; k++) r_xHist[k] <= r_xHist[k-1];
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_d   <= w_fifoHead;
            r_y   <= bus.y_data;
            r_n   <= CNT_W'(clampTaps(bus.tap_count, MAX_TAPS));
            r_cnt <= '0;
            for (int k = 0; k < MAX_TAPS; k++) r_snap[k] <= r_xHist[k];
          end
        end
        ERR: begin
          r_err      <= sat32(w_diff);
          r_errValid <= 1'b1;
          r_cnt      <= '0;
        end
        UPDATE: begin
          r_w[w_idx] <= sat32(w_sum);
          r_cnt      <= w_lastTap ? '0 : r_cnt + 1'b1;
        end
        STREAM: begin
          if (r_cnt == '0) begin
            r_restart <= 1'b1;
          end else if (!w_streamDone) begin
            r_coeffValid <= 1'b1;
            r_coeffData  <= r_w[w_idx];
          end
          r_cnt <= r_cnt + 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Sticky status; a set in the same cycle as clear_status takes priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
      r_yDropped <= 1'b0;
    end else begin
      r_overrun  <= (bus.x_valid && w_fifoFull) || (r_overrun && !bus.clear_status);
      r_underrun <= (bus.y_valid && (r_state == IDLE) && bus.enable && w_fifoEmpty) ||
                    (r_underrun && !bus.clear_status);
      r_yDropped <= (bus.y_valid && ((r_state != IDLE) || !bus.enable)) ||
                    (r_yDropped && !bus.clear_status);
    end
  end

  assign bus.err_valid     = r_errValid;
  assign bus.err_data      = r_err;
  assign bus.coeff_restart = r_restart;
  assign bus.coeff_valid   = r_coeffValid;
  assign bus.coeff_data    = r_coeffData;
  assign bus.busy          = (r_state != IDLE);
  assign bus.overrun       = r_overrun;
  assign bus.underrun      = r_underrun;
  assign bus.y_dropped     = r_yDropped;

endmodule

// File: tb/tb_fir_lms_update.sv
// Self-checking bench for fir_lms_update.
// A transaction-level model predicts, at every accepted y, the error word and the
// complete updated coefficient stream (with the clock edge each should appear on);
// a monitor pops and compares those predictions whenever the DUT presents output.
module tb_fir_lms_update;
  import fir_pkg::*;

  localparam int MAX_TAPS     = 16;
  localparam int FRAC_W       = 16;
  localparam int MU_SHIFT     = 0;
  localparam int D_FIFO_DEPTH = 4;
  localparam int SHIFT        = FRAC_W + MU_SHIFT;
  localparam longint SMAX     = 64'sd2147483647;
  localparam longint SMIN     = -64'sd2147483648;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  fir_lms_update_if bus ();

  fir_lms_update #(
    .MAX_TAPS     (MAX_TAPS),
    .FRAC_W       (FRAC_W),
    .MU_SHIFT     (MU_SHIFT),
    .D_FIFO_DEPTH (D_FIFO_DEPTH)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  int testsRun    = 0;
  int testsFailed = 0;

  exp_t        errQ[$];
  exp_t        coeffQ[$];
  int          restartQ[$];
  logic [31:0] errLog[$];
  logic [31:0] coeffLog[$];
  int          restartCount = 0;

  // Reference model state.
  int mW[MAX_TAPS];
  int mHist[MAX_TAPS];
  int mD[$];
  int mBusy;
  bit mOverrun, mUnderrun, mDropped;
  int cyc = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic int satModel(input longint v);
    if (v > SMAX) return int'(SMAX);
    if (v < SMIN) return int'(SMIN);
    return int'(v);
  endfunction

  task automatic modelReset();
    for (int k = 0; k < MAX_TAPS; k++) begin
      mW[k]    = 0;
      mHist[k] = 0;
    end
    mD.delete();
    errQ.delete();
    coeffQ.delete();
    restartQ.delete();
    mBusy     = 0;
    mOverrun  = 0;
    mUnderrun = 0;
    mDropped  = 0;
  endtask

  task automatic modelAccept();
    int unsigned tc = bus.tap_count;
    int n, d, y, e;
    longint delta;
    if (tc == 0) n = 1;
    else if (tc > MAX_TAPS) n = MAX_TAPS;
    else n = int'(tc);
    d = mD.pop_front();
    y = bus.y_data;
    e = satModel(longint'(d) - longint'(y));
    errQ.push_back('{data: e, cyc: cyc + 1});
    for (int k = 0; k < n; k++) begin
      delta = (longint'(e) * longint'(mHist[k])) >>> SHIFT;
      mW[k] = satModel(longint'(mW[k]) + delta);
    end
    restartQ.push_back(cyc + n + 2);
    for (int k = 0; k < n; k++) coeffQ.push_back('{data: mW[k], cyc: cyc + n + 3 + k});
    mBusy = 2 * n + 3;
  endtask

  task automatic modelEdge();
    bit busyBefore = (mBusy > 0);
    bit fullBefore = (mD.size() >= D_FIFO_DEPTH);
    bit setOv = 0, setUn = 0, setDr = 0;
    cyc++;
    if (busyBefore) mBusy--;
    if (bus.y_valid) begin
      if (busyBefore || !bus.enable) setDr = 1;
      else if (mD.size() == 0) setUn = 1;
      else modelAccept();
    end
    if (bus.x_valid) begin
      if (fullBefore) setOv = 1;
      else mD.push_back(bus.d_data);
      for (int k = MAX_TAPS - 1; k > 0; k--) mHist[k] = mHist[k-1];
      mHist[0] = bus.x_data;
    end
    mOverrun  = setOv | (mOverrun  & !bus.clear_status);
    mUnderrun = setUn | (mUnderrun & !bus.clear_status);
    mDropped  = setDr | (mDropped  & !bus.clear_status);
  endtask

  // Model advances on every active edge; reset flushes it along with pending expectations.
  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) modelReset();
      else modelEdge();
    end
  end

  task automatic monitorCycle();
    exp_t ex;
    int rc;
    checkOutput("busy", bus.busy, mBusy > 0);
    checkOutput("overrun", bus.overrun, mOverrun);
    checkOutput("underrun", bus.underrun, mUnderrun);
    checkOutput("y_dropped", bus.y_dropped, mDropped);
    if (bus.err_valid) begin
      if (errQ.size() == 0) checkOutput("err_valid_unexpected", bus.err_valid, 0);
      else begin
        ex = errQ.pop_front();
        checkOutput("err_data", bus.err_data, ex.data);
        checkOutput("err_cycle", cyc, ex.cyc);
        errLog.push_back(bus.err_data);
      end
    end else if (errQ.size() > 0 && errQ[0].cyc <= cyc) begin
      checkOutput("err_valid_missing", bus.err_valid, 1);
      void'(errQ.pop_front());
    end
    if (bus.coeff_restart) begin
      restartCount++;
      if (restartQ.size() == 0) checkOutput("coeff_restart_unexpected", bus.coeff_restart, 0);
      else begin
        rc = restartQ.pop_front();
        checkOutput("coeff_restart_cycle", cyc, rc);
      end
    end else if (restartQ.size() > 0 && restartQ[0] <= cyc) begin
      checkOutput("coeff_restart_missing", bus.coeff_restart, 1);
      void'(restartQ.pop_front());
    end
    if (bus.coeff_valid) begin
      coeffLog.push_back(bus.coeff_data);
      if (coeffQ.size() == 0) checkOutput("coeff_valid_unexpected", bus.coeff_valid, 0);
      else begin
        ex = coeffQ.pop_front();
        checkOutput("coeff_data", bus.coeff_data, ex.data);
        checkOutput("coeff_cycle", cyc, ex.cyc);
      end
    end else if (coeffQ.size() > 0 && coeffQ[0].cyc <= cyc) begin
      checkOutput("coeff_valid_missing", bus.coeff_valid, 1);
      void'(coeffQ.pop_front());
    end
  endtask

  // Monitor samples DUT outputs on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) monitorCycle();
    end
  end

  // One clock of stimulus; strobes are dropped again after the edge.
  task automatic applyStimulus(input bit xv, input logic [31:0] xd, input logic [31:0] dd,
                               input bit yv, input logic [31:0] yd, input bit clr);
    bus.x_valid      = xv;
    bus.x_data       = xd;
    bus.d_data       = dd;
    bus.y_valid      = yv;
    bus.y_data       = yd;
    bus.clear_status = clr;
    @(negedge clk);
    bus.x_valid      = 1'b0;
    bus.y_valid      = 1'b0;
    bus.clear_status = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    rstn             = 1'b0;
    bus.x_valid      = 1'b0;
    bus.y_valid      = 1'b0;
    bus.clear_status = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(1);
  endtask

  function automatic logic [31:0] randData();
    logic [31:0] v;
    if ($urandom_range(0, 3) == 0) begin
      v = $urandom;
    end else begin
      v = $urandom_range(0, 32'h0003_FFFF);
      if ($urandom_range(0, 1) == 1) v = -v;
    end
    return v;
  endfunction

  int eBase, cBase, rBase;

  initial begin
    bus.tap_count    = 32'd2;
    bus.enable       = 1'b1;
    bus.x_valid      = 1'b0;
    bus.x_data       = '0;
    bus.d_data       = '0;
    bus.y_valid      = 1'b0;
    bus.y_data       = '0;
    bus.clear_status = 1'b0;

    // Reset values.
    idle(2);
    checkOutput("rst_err_valid", bus.err_valid, 0);
    checkOutput("rst_err_data", bus.err_data, 0);
    checkOutput("rst_coeff_restart", bus.coeff_restart, 0);
    checkOutput("rst_coeff_valid", bus.coeff_valid, 0);
    checkOutput("rst_coeff_data", bus.coeff_data, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_flags", {bus.overrun, bus.underrun, bus.y_dropped}, 0);
    rstn = 1'b1;
    idle(1);

    // Basic update: history {1.0, 0.5}, e = 1.0.
    eBase = errLog.size(); cBase = coeffLog.size();
    bus.tap_count = 32'd2;
    applyStimulus(1, 32'h0000_8000, 32'h0001_0000, 0, 0, 0);
    applyStimulus(1, 32'h0001_0000, 32'h0001_0000, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h0, 0);
    idle(12);
    checkOutput("basic_err", errLog[eBase], 32'h0001_0000);
    checkOutput("basic_w0", coeffLog[cBase], 32'h0001_0000);
    checkOutput("basic_w1", coeffLog[cBase+1], 32'h0000_8000);
    checkOutput("basic_words", coeffLog.size() - cBase, 2);

    // Saturation, positive then negative.
    doReset();
    bus.tap_count = 32'd1;
    applyStimulus(1, 32'h7FFF_0000, 32'h0001_0000, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h0, 0);
    idle(10);
    checkOutput("sat_preload_w0", coeffLog[coeffLog.size()-1], 32'h7FFF_0000);
    eBase = errLog.size();
    applyStimulus(1, 32'h7FFF_0000, 32'h7FFF_FFFF, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h8000_0000, 0);
    idle(10);
    checkOutput("sat_err_pos", errLog[eBase], 32'h7FFF_FFFF);
    checkOutput("sat_w0_pos", coeffLog[coeffLog.size()-1], 32'h7FFF_FFFF);
    applyStimulus(1, 32'h7FFF_0000, 32'h8000_0000, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h7FFF_FFFF, 0);
    idle(10);
    checkOutput("sat_err_neg", errLog[eBase+1], 32'h8000_0000);
    checkOutput("sat_w0_neg", coeffLog[coeffLog.size()-1], 32'h8000_0000);

    // Second y while busy is dropped; the first stream still completes.
    doReset();
    bus.tap_count = 32'd4;
    cBase = coeffLog.size(); rBase = restartCount;
    applyStimulus(1, 32'h0002_0000, 32'h0000_4000, 0, 0, 0);
    applyStimulus(1, 32'hFFFF_0000, 32'h0000_2000, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h0000_1000, 0);
    idle(2);
    applyStimulus(0, 0, 0, 1, 32'h0000_3000, 0);
    idle(20);
    checkOutput("drop_flag", bus.y_dropped, 1);
    checkOutput("drop_words", coeffLog.size() - cBase, 4);
    checkOutput("drop_restarts", restartCount - rBase, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("drop_cleared", bus.y_dropped, 0);
    bus.enable = 1'b0;
    applyStimulus(0, 0, 0, 1, 32'h0, 1);
    checkOutput("drop_set_wins", bus.y_dropped, 1);
    bus.enable = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1);

    // FIFO overrun keeps the first four, then underrun after they are consumed.
    doReset();
    bus.tap_count = 32'd1;
    eBase = errLog.size();
    for (int i = 0; i < 5; i++) applyStimulus(1, 32'h0000_0100, 32'h0000_1000 * (i + 1), 0, 0, 0);
    checkOutput("fifo_overrun", bus.overrun, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, 32'h0, 0);
      idle(8);
    end
    for (int i = 0; i < 4; i++) checkOutput("fifo_order", errLog[eBase+i], 32'h0000_1000 * (i + 1));
    applyStimulus(0, 0, 0, 1, 32'h0, 0);
    idle(4);
    checkOutput("fifo_underrun", bus.underrun, 1);
    checkOutput("fifo_no_err", errLog.size() - eBase, 4);

    // Tap-count clamping.
    doReset();
    bus.tap_count = 32'd0;
    cBase = coeffLog.size();
    applyStimulus(1, 32'h0001_0000, 32'h0000_8000, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h0, 0);
    idle(8);
    checkOutput("clamp_low_words", coeffLog.size() - cBase, 1);
    bus.tap_count = 32'd40;
    cBase = coeffLog.size();
    applyStimulus(1, 32'h0000_4000, 32'h0000_8000, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h0000_1000, 0);
    idle(38);
    checkOutput("clamp_high_words", coeffLog.size() - cBase, 16);

    // Reset while streaming aborts the stream and clears the bank.
    bus.tap_count = 32'd4;
    applyStimulus(1, 32'h0003_0000, 32'h0002_0000, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h0, 0);
    for (int i = 0; i < 20 && !bus.coeff_valid; i++) @(negedge clk);
    checkOutput("mid_stream_reached", bus.coeff_valid, 1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("mid_reset_coeff_valid", bus.coeff_valid, 0);
    checkOutput("mid_reset_busy", bus.busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    idle(1);
    bus.tap_count = 32'd40;
    cBase = coeffLog.size();
    applyStimulus(1, 32'h0005_0000, 32'h0000_1234, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h0000_1234, 0);
    idle(38);
    checkOutput("post_reset_words", coeffLog.size() - cBase, 16);
    for (int i = 0; i < 16; i++) checkOutput("post_reset_zero", coeffLog[cBase+i], 0);

    // Randomised traffic.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) bus.tap_count = $urandom_range(0, 20);
      bus.enable = ($urandom_range(0, 9) != 0);
      applyStimulus($urandom_range(0, 9) < 3, randData(), randData(),
                    $urandom_range(0, 9) < 2, randData(), $urandom_range(0, 19) == 0);
    end
    bus.enable = 1'b1;
    idle(45);
    checkOutput("drain_err", errQ.size(), 0);
    checkOutput("drain_coeff", coeffQ.size(), 0);
    checkOutput("drain_restart", restartQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fir_lms_update.md
Name: fir_lms_update

Overview:
- Downstream stage of the FIR datapath; closes the adaptive loop.
- Consumes each filter output y[n], pairs it with the matching desired sample d[n], and computes error e = d - y.
- Applies a sign-preserving LMS step w[k] += (e*x[n-k]) >>> (FRAC_W+MU_SHIFT) to its own coefficient bank.
- Streams the updated coefficient set back toward the datapath coefficient-load port.

Parameters:
- MAX_TAPS, 16, coefficient and sample-history depth.
- FRAC_W, 16, fractional bits of the Q(32-FRAC_W).FRAC_W data format.
- MU_SHIFT, 8, step size mu = 2^-MU_SHIFT.
- D_FIFO_DEPTH, 4, desired-sample FIFO depth (power of 2).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- tap_count  in  32  requested taps; effective N = clamp(tap_count, 1, MAX_TAPS), latched at y accept
- enable  in  1  adaptation enable
- x_valid  in  1  new input sample (same strobe as datapath input_data_valid)
- x_data  in  32 signed  input sample
- d_data  in  32 signed  desired sample, qualified by x_valid
- y_valid  in  1  filter output valid
- y_data  in  32 signed  filter output
- clear_status  in  1  clears sticky flags
- err_valid  out  1  one-cycle error strobe
- err_data  out  32 signed  saturated error
- coeff_restart  out  1  one-cycle pulse preceding a coefficient stream
- coeff_valid  out  1  coefficient word valid
- coeff_data  out  32 signed  coefficient word, order w[0]..w[N-1]
- busy  out  1  update or stream in progress
- overrun  out  1  sticky: desired sample dropped on full FIFO
- underrun  out  1  sticky: y arrived with FIFO empty
- y_dropped  out  1  sticky: y arrived while busy or disabled

Behaviour:
- Reset (async, rstn=0):
  - All outputs 0; coefficients 0; history 0; FIFO empty; state IDLE.
  - Reset mid-update or mid-stream aborts immediately; no partial stream resumes.
- History: on x_valid, x_hist shifts (x_hist[0] = x_data, x_hist[k] = x_hist[k-1]) and d_data is pushed into the FIFO.
  - FIFO full: push discarded, overrun = 1; the history shift still occurs.
- Accept: y accepted at edge E0 iff state IDLE, enable = 1, y_valid = 1, FIFO non-empty.
  - On accept: pop d; snapshot x_hist into snap[]; latch N.
  - y_valid while busy or enable = 0: y ignored, y_dropped = 1.
  - y_valid with FIFO empty in IDLE: y ignored, underrun = 1.
  - Simultaneous x_valid and accept: the pop uses the pre-push head; the snapshot uses pre-shift history.
- Timing:
  - E1: err_data = sat32(d - y), err_valid = 1 for one cycle; state UPDATE.
  - E2..E(N+1): one tap per cycle, k = 0..N-1: p = e * snap[k] (64-bit signed); delta = p >>> (FRAC_W+MU_SHIFT) (floor); w[k] = sat32(w[k] + delta).
  - E(N+2): coeff_restart = 1; state STREAM.
  - E(N+3)..E(2N+2): coeff_valid = 1, coeff_data = w[0..N-1], consecutive cycles, no backpressure.
  - E(2N+3): state IDLE, busy = 0.
- busy = 1 in ERR/UPDATE/STREAM, i.e. from E1 through E(2N+2).
- Taps k >= N are left unchanged.
- Saturation: sat32 clamps to [0x80000000, 0x7FFFFFFF].
- States: IDLE, ERR, UPDATE, STREAM.
  - IDLE to ERR on accept.
  - ERR to UPDATE unconditionally.
  - UPDATE to STREAM when k = N-1.
  - STREAM to IDLE after word N-1.
- enable falling mid-operation: the current update and stream complete.
- clear_status: clears all sticky flags next edge. A same-cycle set wins.
- tap_count changes mid-operation have no effect until the next accept.

Decomposition:
- Package fir_pkg holds:
  - the DATA_W = 32 constant;
  - the lms_state_t enum {IDLE, ERR, UPDATE, STREAM};
  - the sat32 function (signed 33- or 64-bit in, 32 out);
  - the tap-clamp function.
- One sub-module: fir_desired_fifo (sync FIFO, D_FIFO_DEPTH, full/empty, async active-low reset).

Test Plan:
- Basic update: MU_SHIFT = 0, FRAC_W = 16, tap_count = 2; x = 0x00008000 then 0x00010000 (so x_hist[0] = 1.0, x_hist[1] = 0.5); d = 0x00010000 with the second x; y = 0 -> err_data = 0x00010000; coeff_restart, then 0x00010000, 0x00008000. Total 2N+3 = 7 edges to IDLE.
- Saturation: w[0] preloaded near 0x7FFF0000 via repeated updates; large positive e and x -> w[0] = 0x7FFFFFFF, no wrap. Also d = 0x7FFFFFFF, y = 0x80000000 -> err_data = 0x7FFFFFFF.
- Busy drop: second y_valid at E3 with tap_count = 4 -> ignored, y_dropped = 1, exactly 4 coeff words streamed; clear_status -> y_dropped = 0.
- FIFO boundaries: 5 x_valid with no y -> overrun = 1, FIFO holds the first 4 d values in order. Then y with FIFO empty after 4 accepts -> underrun = 1, no err_valid.
- Clamp: tap_count = 0 -> N = 1, one coeff word streamed. tap_count = 40 -> N = 16, 16 words streamed.
- Reset mid-stream: rstn low during STREAM -> coeff_valid = 0 immediately, all coefficients read 0 on the next full update with e = 0.
